// File: rtl/timer_sched_if.sv
// Register bus between the scheduler (master) and the shared 16-bit system timer (slave).
interface timer_sched_if;
  logic       t_cs;
  logic       t_we;
  logic [1:0] t_addr;
  logic [7:0] t_dbw;
  logic [7:0] t_dbr;

  modport master (output t_cs, t_we, t_addr, t_dbw, input t_dbr);
  modport slave  (input t_cs, t_we, t_addr, t_dbw, output t_dbr);
endinterface

// File: rtl/timer_sched.sv
// Round-robin owner of the shared system timer: reloads the count so it equals the
// requested delay, starts the timer, polls for the shot and pulses done to the owner.
module timer_sched #(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0][15:0] delay,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [2:0]            gnt_id,
  timer_sched_if.master         tbus
);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_STOP  = 4'd1;
  localparam logic [3:0] S_RDLO  = 4'd2;
  localparam logic [3:0] S_RDHI  = 4'd3;
  localparam logic [3:0] S_CAPHI = 4'd4;
  localparam logic [3:0] S_WRLO  = 4'd5;
  localparam logic [3:0] S_WRHI  = 4'd6;
  localparam logic [3:0] S_START = 4'd7;
  localparam logic [3:0] S_POLL  = 4'd8;
  localparam logic [3:0] S_CHK   = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  logic [3:0]      state;
  logic [2:0]      last, win;
  logic [15:0]     n, d, sel_delay;
  logic [7:0]      c_lo;
  logic [NREQ-1:0] hi_req;
  logic            cs, we;
  logic [1:0]      addr;
  logic [7:0]      dbw;

  // Requesters above the last winner take priority; otherwise wrap to the lowest index.
  always_comb begin
    hi_req    = '0;
    win       = '0;
    sel_delay = '0;
    for (int i = 0; i < NREQ; i++) hi_req[i] = req[i] && (3'(i) > last);
    for (int i = NREQ - 1; i >= 0; i--) if (req[i]) win = 3'(i);
    if (|hi_req)
      for (int i = NREQ - 1; i >= 0; i--) if (hi_req[i]) win = 3'(i);
    for (int i = 0; i < NREQ; i++) if (win == 3'(i)) sel_delay = delay[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      last   <= 3'(NREQ - 1);
      gnt_id <= '0;
      n      <= '0;
      d      <= '0;
      c_lo   <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          gnt_id <= win;
          last   <= win;
          n      <= sel_delay;
          state  <= (sel_delay == 16'd0) ? S_DONE : S_STOP;
        end
        S_STOP:  state <= S_RDLO;
        S_RDLO:  state <= S_RDHI;
        S_RDHI:  begin c_lo <= tbus.t_dbr; state <= S_CAPHI; end
        // Adding N - C onto the stopped count leaves exactly N in the timer.
        S_CAPHI: begin d <= n - {tbus.t_dbr, c_lo}; state <= S_WRLO; end
        S_WRLO:  state <= S_WRHI;
        S_WRHI:  state <= S_START;
        S_START: state <= S_POLL;
        S_POLL:  state <= S_CHK;
        S_CHK:   state <= tbus.t_dbr[7] ? S_DONE : S_POLL;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cs   = 1'b0;
    we   = 1'b0;
    addr = 2'd0;
    dbw  = 8'h00;
    case (state)
      S_STOP:  begin cs = 1'b1; we = 1'b1; addr = 2'd2; end
      S_RDLO:  begin cs = 1'b1; addr = 2'd0; end
      S_RDHI:  begin cs = 1'b1; addr = 2'd1; end
      S_WRLO:  begin cs = 1'b1; we = 1'b1; addr = 2'd0; dbw = d[7:0]; end
      S_WRHI:  begin cs = 1'b1; we = 1'b1; addr = 2'd1; dbw = d[15:8]; end
      S_START: begin cs = 1'b1; we = 1'b1; addr = 2'd2; dbw = 8'h01; end
      S_POLL:  begin cs = 1'b1; addr = 2'd2; end
      S_DONE:  begin cs = 1'b1; we = 1'b1; addr = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < NREQ; i++) done[i] = (state == S_DONE) && (gnt_id == 3'(i));
  end

  assign busy        = (state != S_IDLE);
  assign tbus.t_cs   = cs;
  assign tbus.t_we   = we;
  assign tbus.t_addr = addr;
  assign tbus.t_dbw  = dbw;
endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares the single 16-bit system timer among `NREQ` requesters. It sits between the requesters and the timer's register bus, and it is the timer's only bus master. For each granted request it stops the timer, reads the current count, and adds the correction that makes the count equal the requested delay. It then starts the timer, polls the shot flag, and pulses `done` to the owning requester.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  NREQ  level request, one bit per requester.
- `delay`  in  16*NREQ  requested delay N; requester i uses bits [16i+15:16i].
- `done`  out  NREQ  one-cycle completion pulse to the owning requester.
- `busy`  out  1  high in every state except IDLE.
- `gnt_id`  out  3  index of the current owner; valid while `busy`.
- `t_cs`  out  1  timer chip select.
- `t_we`  out  1  timer write (1) / read (0).
- `t_addr`  out  2  timer register: 0 = count lo, 1 = count hi, 2 = control/status.
- `t_dbw`  out  8  timer write data.
- `t_dbr`  in  8  timer read data, registered: valid the cycle after the read strobe.

## Operation
- Timer register semantics:
  - A write to addr 0 adds `t_dbw` to the 16-bit count.
  - A write to addr 1 adds `t_dbw` to count[15:8].
  - A write to addr 2 sets shot = bit 7 and active = bit 0.
  - A read of addr 2 returns {shot, 6'b0, active}.
- FSM states: IDLE, STOP, RDLO, RDHI, CAPHI, WRLO, WRHI, START, POLL, CHK, DONE.
- Bus outputs are decoded from state only (Moore). `t_cs` is 0 and `t_dbw` is 0 in every state not listed below.
- IDLE:
  - If any `req` bit is set, pick the winner by round-robin, searching from `last+1` upward with wrap.
  - Latch `gnt_id` and N = that requester's `delay`; set `last` = winner.
  - Go to DONE if N == 0, otherwise to STOP.
- STOP: write addr 2, 0x00. This stops the timer and clears shot.
- RDLO: read addr 0.
- RDHI: read addr 1; capture `t_dbr` as C[7:0].
- CAPHI: no bus access; capture `t_dbr` as C[15:8]; compute D = (N − C) mod 2^16.
- WRLO: write addr 0, D[7:0].
- WRHI: write addr 1, D[15:8]. The count now equals N.
- START: write addr 2, 0x01.
- POLL: read addr 2.
- CHK: no bus access. If `t_dbr[7]` is 1, go to DONE; otherwise go to POLL.
- DONE: write addr 2, 0x00; assert `done[gnt_id]`; go to IDLE.
- A `req` bit dropping while its owner is being serviced is ignored; the operation completes and `done` still pulses.
- A `req` bit still high in the cycle after `done` is treated as a new request.
- The timer's state at entry is irrelevant, because STOP and the read-back re-establish it. The timer may be stopped or running with any count.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State goes to IDLE.
  - `done`, `busy`, `t_cs`, `t_we`, `t_addr` and `t_dbw` are 0; `gnt_id` is 0.
  - `last` is reset to NREQ−1, so requester 0 wins first.
- Reset mid-operation abandons the operation and no `done` is produced. The timer itself is not reset by this block.
- Cycle numbering: cycle 0 is the IDLE cycle that samples `req`.
  - STOP = 1, RDLO = 2, RDHI = 3, CAPHI = 4, WRLO = 5, WRHI = 6, START = 7.
  - POLL/CHK alternate from cycle 8, two cycles per poll.
- Completion latency:
  - For N ≥ 1, DONE (the `done` pulse) occurs in cycle N+11 or N+12.
  - For N = 0, DONE occurs in cycle 1.
- The cycle after DONE is IDLE, so back-to-back grants are separated by exactly one IDLE cycle.
- `busy` is high from cycle 1 through DONE inclusive.
- Arithmetic: D is computed mod 2^16. The carry from the lo write propagates into the count inside the timer. No saturation; N = 0xFFFF is legal.

## Test plan
- Single request, N = 5, timer preloaded running at count 0x1234 → bus sequence:
  - STOP write (2, 0x00).
  - Reads of addr 0 and addr 1.
  - Write (0, 0xD1), write (1, 0xED), write (2, 0x01).
  - `done[0]` pulses in cycle 16 or 17, followed by write (2, 0x00).
- Requests 0 and 2 asserted together and held, N = 3 each → grants in order 0, 2, 0, 2. `gnt_id` matches each `done` bit, with one IDLE cycle between operations.
- N = 0 on requester 1 → `done[1]` in cycle 1, only bus access is (2, 0x00), no reads.
- Wrap case: C = 0x0001, N = 0xFFFF → D = 0xFFFE. Writes (0, 0xFE) then (1, 0xFF); the count checked via a bench-side read equals 0xFFFF.
- Reset asserted during POLL → all outputs 0 immediately. After release, the next request restarts from STOP and completes normally.
- Requester deasserts `req` in cycle 4 → the operation completes and `done` still pulses for that requester.
